// File: rtl/any1_pkg.sv
// Shared types for the ANY1 back end: functional-unit result record,
// unit codes, fault encoding and the writeback-priority class helper.
package any1_pkg;

  localparam int NFU_DEFAULT = 6;
  localparam int UNIT_W      = 3;

  typedef enum logic [UNIT_W-1:0] {
    FU_EXEC = 3'd0,
    FU_MUL  = 3'd1,
    FU_DIV  = 3'd2,
    FU_FPU  = 3'd3,
    FU_MEM  = 3'd4,
    FU_GR   = 3'd5
  } e_fu;

  localparam logic [7:0] FLT_NONE = 8'h00;

  typedef struct packed {
    logic        cmt;
    logic [5:0]  rid;
    logic [7:0]  ele;
    logic [63:0] res;
    logic [7:0]  cause;
    logic [31:0] badAddr;
  } sFuncUnit;

  // Faulting results form the high-priority writeback class.
  function automatic logic is_flt(input logic [7:0] cause);
    return cause != FLT_NONE;
  endfunction

endpackage

// File: rtl/any1_rr_picker.sv
// Rotating find-first: searches req_i starting at rr_i, wrapping modulo N,
// and returns the first set bit as one-hot and as an index.
module any1_rr_picker
  import any1_pkg::*;
#(
  parameter int N  = NFU_DEFAULT,
  parameter int IW = UNIT_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Walk offsets 0..N-1 from rr_i; the first valid request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/any1_fu_wb_arbiter.sv
// Functional-unit writeback arbiter: one hold slot per unit, a single
// registered writeback port to the ROB, faults first, round-robin within class.
module any1_fu_wb_arbiter
  import any1_pkg::*;
#(
  parameter int NFU = NFU_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NFU-1:0]        fu_req_i,
  input  sFuncUnit [NFU-1:0]    fu_res_i,
  output logic [NFU-1:0]        fu_ack_o,
  input  logic                  flush_i,
  output logic                  wb_v_o,
  output sFuncUnit              wb_o,
  output logic [UNIT_W-1:0]     wb_unit_o,
  input  logic                  wb_rdy_i,
  output logic [15:0]           stall_cnt_o
);

  localparam int IW = UNIT_W;

  logic [NFU-1:0]     hv_q, hv_d;
  sFuncUnit [NFU-1:0] hb_q;
  logic               wb_v_q;
  sFuncUnit           wb_q;
  logic [IW-1:0]      unit_q;
  logic [IW-1:0]      rr_q, rr_d;
  logic [15:0]        stall_q;

  logic [NFU-1:0] flt, req1, req0, gnt1, gnt0, gnt;
  logic [IW-1:0]  idx1, idx0, gidx;
  logic           any1, any0, do_gnt;

  // Classify each held result by its fault cause.
  always_comb begin
    flt = '0;
    for (int n = 0; n < NFU; n++) flt[n] = is_flt(hb_q[n].cause);
  end

  assign req1 = hv_q & flt;
  assign req0 = hv_q & ~flt;

  any1_rr_picker #(.N(NFU), .IW(IW)) u_pick_flt (
    .req_i(req1), .rr_i(rr_q), .gnt_o(gnt1), .idx_o(idx1), .any_o(any1)
  );

  any1_rr_picker #(.N(NFU), .IW(IW)) u_pick_ok (
    .req_i(req0), .rr_i(rr_q), .gnt_o(gnt0), .idx_o(idx0), .any_o(any0)
  );

  // Output register can take a new record when empty or being drained;
  // a flush suppresses the grant entirely.
  assign do_gnt = (!wb_v_q || wb_rdy_i) && (any1 || any0) && !flush_i;
  assign gidx   = any1 ? idx1 : idx0;
  assign gnt    = do_gnt ? (any1 ? gnt1 : gnt0) : '0;

  // A unit may hand over when its slot is empty or is being emptied now.
  assign fu_ack_o = rst_ni ? (fu_req_i & ~(hv_q & ~gnt) & {NFU{!flush_i}}) : '0;

  // Next-state for hold valids and the round-robin pointer.
  always_comb begin
    hv_d = flush_i ? '0 : ((hv_q & ~gnt) | fu_ack_o);
    rr_d = rr_q;
    if (do_gnt) rr_d = (gidx == IW'(NFU-1)) ? '0 : gidx + IW'(1);
  end

  // Hold buffers: capture a unit's result on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hv_q <= '0;
      hb_q <= '0;
    end else begin
      hv_q <= hv_d;
      for (int n = 0; n < NFU; n++)
        if (fu_ack_o[n]) hb_q[n] <= fu_res_i[n];
    end
  end

  // Writeback register: load the winner, stay put under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_v_q <= 1'b0;
      wb_q   <= '0;
      unit_q <= '0;
      rr_q   <= '0;
    end else if (flush_i) begin
      wb_v_q <= 1'b0;
    end else if (do_gnt) begin
      wb_v_q <= 1'b1;
      wb_q   <= hb_q[gidx];
      unit_q <= gidx;
      rr_q   <= rr_d;
    end else if (wb_rdy_i) begin
      wb_v_q <= 1'b0;
    end
  end

  // Saturating count of cycles the ROB refused a valid record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else if (!flush_i && wb_v_q && !wb_rdy_i && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign wb_v_o      = wb_v_q;
  assign wb_o        = wb_q;
  assign wb_unit_o   = unit_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_any1_fu_wb_arbiter.sv
// Directed bench for the writeback arbiter: latency, round-robin order,
// fault priority, backpressure, flush, counter saturation, async reset.
module tb_any1_fu_wb_arbiter;
  import any1_pkg::*;

  localparam int NFU = 6;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [NFU-1:0]     fu_req_i;
  sFuncUnit [NFU-1:0] fu_res_i;
  logic [NFU-1:0]     fu_ack_o;
  logic               flush_i;
  logic               wb_v_o;
  sFuncUnit           wb_o;
  logic [2:0]         wb_unit_o;
  logic               wb_rdy_i;
  logic [15:0]        stall_cnt_o;

  int errs = 0, checks = 0;

  any1_fu_wb_arbiter #(.NFU(NFU)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fu_req_i(fu_req_i), .fu_res_i(fu_res_i),
    .fu_ack_o(fu_ack_o), .flush_i(flush_i), .wb_v_o(wb_v_o), .wb_o(wb_o),
    .wb_unit_o(wb_unit_o), .wb_rdy_i(wb_rdy_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input int u, input logic [5:0] rid, input logic [7:0] cause);
    fu_req_i[u]       = 1'b1;
    fu_res_i[u]       = '0;
    fu_res_i[u].rid   = rid;
    fu_res_i[u].cause = cause;
    fu_res_i[u].res   = 64'(rid) * 64'd3 + 64'd1;
  endtask

  task automatic wbchk(input string tag, input logic [2:0] unit, input logic [5:0] rid);
    chk({tag, "_v"}, wb_v_o, 1);
    chk({tag, "_unit"}, wb_unit_o, unit);
    chk({tag, "_rid"}, wb_o.rid, rid);
  endtask

  initial begin
    fu_req_i = '0; fu_res_i = '0; flush_i = 0; wb_rdy_i = 1; rst_ni = 0;

    // reset state, acks held low even with requests present
    #2 fu_req_i = '1;
    #1;
    chk("rst_ack", fu_ack_o, 0);
    chk("rst_v", wb_v_o, 0);
    chk("rst_unit", wb_unit_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    fu_req_i = '0;
    tick();
    rst_ni = 1;

    // single result through MUL: 2-edge latency, one cycle valid
    put(FU_MUL, 6'd3, 8'h00);
    #1 chk("single_ack", fu_ack_o, 6'b000010);
    tick(); fu_req_i = '0;
    chk("single_lat1", wb_v_o, 0);
    tick(); wbchk("single", 3'd1, 6'd3);
    chk("single_res", wb_o.res, 64'd10);
    tick(); chk("single_done", wb_v_o, 0);

    // round-robin from rr=0 with all units
    rst_ni = 0; #1 rst_ni = 1;
    for (int u = 0; u < NFU; u++) put(u, 6'(u), 8'h00);
    #1 chk("rr_ack", fu_ack_o, 6'h3F);
    tick(); fu_req_i = '0;
    for (int u = 0; u < NFU; u++) begin
      tick(); wbchk($sformatf("rr%0d", u), 3'(u), 6'(u));
    end
    tick(); chk("rr_idle", wb_v_o, 0);

    // rr wrapped back to 0: unit 1 beats unit 5
    put(5, 6'd15, 8'h00); put(1, 6'd11, 8'h00);
    tick(); fu_req_i = '0;
    tick(); wbchk("wrap_a", 3'd1, 6'd11);
    tick(); wbchk("wrap_b", 3'd5, 6'd15);
    tick(); chk("wrap_idle", wb_v_o, 0);

    // fault class first, then normal; rr ends at 1
    put(0, 6'd20, 8'h00); put(4, 6'd21, 8'h27);
    tick(); fu_req_i = '0;
    tick(); wbchk("exc_a", 3'd4, 6'd21);
    tick(); wbchk("exc_b", 3'd0, 6'd20);
    put(0, 6'd22, 8'h00); put(1, 6'd23, 8'h00);
    tick(); fu_req_i = '0;
    tick(); wbchk("exc_rr_a", 3'd1, 6'd23);
    tick(); wbchk("exc_rr_b", 3'd0, 6'd22);
    tick(); chk("exc_idle", wb_v_o, 0);

    // backpressure with unit 2 re-requesting
    wb_rdy_i = 0; put(2, 6'd10, 8'h00);
    tick();
    fu_res_i[2].rid = 6'd11;
    tick(); wbchk("bp_first", 3'd2, 6'd10);
    fu_res_i[2].rid = 6'd12;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("bp_ack%0d", i), fu_ack_o[2], 0);
      tick(); chk($sformatf("bp_rid%0d", i), wb_o.rid, 6'd10);
      chk($sformatf("bp_v%0d", i), wb_v_o, 1);
    end
    chk("bp_stall", stall_cnt_o, 16'd10);
    wb_rdy_i = 1;
    #1 chk("bp_rel_ack", fu_ack_o[2], 1);
    tick(); fu_req_i = '0;
    wbchk("bp_r1", 3'd2, 6'd11);
    tick(); wbchk("bp_r2", 3'd2, 6'd12);
    tick(); chk("bp_idle", wb_v_o, 0);
    chk("bp_stall_hold", stall_cnt_o, 16'd10);

    // flush with three holds and a stalled output; rr is 3 here
    wb_rdy_i = 0;
    put(0, 6'd40, 8'h00); put(1, 6'd41, 8'h00); put(3, 6'd43, 8'h00); put(4, 6'd44, 8'h00);
    tick(); fu_req_i = '0;
    tick(); wbchk("fl_pre", 3'd3, 6'd43);
    flush_i = 1; put(2, 6'd50, 8'h00); put(5, 6'd51, 8'h00); put(0, 6'd52, 8'h00);
    #1 chk("fl_ack", fu_ack_o, 0);
    tick(); flush_i = 0; fu_req_i = '0;
    chk("fl_v", wb_v_o, 0);
    chk("fl_stall", stall_cnt_o, 16'd10);
    fu_req_i = '1;
    #1 chk("fl_hv_clear", fu_ack_o, 6'h3F);
    fu_req_i = '0;
    wb_rdy_i = 1;
    tick(); chk("fl_stay_idle", wb_v_o, 0);
    // rr kept at 4 through the flush
    put(0, 6'd30, 8'h00); put(4, 6'd34, 8'h00);
    tick(); fu_req_i = '0;
    tick(); wbchk("fl_rr_a", 3'd4, 6'd34);
    tick(); wbchk("fl_rr_b", 3'd0, 6'd30);
    tick(); chk("fl_idle", wb_v_o, 0);

    // stall counter saturation, then async reset mid-stream
    wb_rdy_i = 0; put(5, 6'd33, 8'h00);
    tick(); fu_req_i = '0;
    tick(); wbchk("sat_pre", 3'd5, 6'd33);
    repeat (65530) @(posedge clk_i);
    #1 chk("sat_stall", stall_cnt_o, 16'hFFFF);
    tick(); chk("sat_hold", stall_cnt_o, 16'hFFFF);
    #2 rst_ni = 0; fu_req_i = '1;
    #1;
    chk("arst_v", wb_v_o, 0);
    chk("arst_unit", wb_unit_o, 0);
    chk("arst_wb", |wb_o, 0);
    chk("arst_stall", stall_cnt_o, 0);
    chk("arst_ack", fu_ack_o, 0);
    fu_req_i = '0; wb_rdy_i = 1;
    tick(); rst_ni = 1;

    // resumes after reset
    put(3, 6'd7, 8'h00);
    tick(); fu_req_i = '0;
    chk("resume_lat1", wb_v_o, 0);
    tick(); wbchk("resume", 3'd3, 6'd7);
    tick(); chk("resume_idle", wb_v_o, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/any1_fu_wb_arbiter.md
ANY1_FU_WB_ARBITER -- requirements
Module: any1_fu_wb_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk_i input 1 rising-edge clock; rst_ni input 1 async active-low reset.
REQ-002 SHALL have parameter NFU, default 6, number of functional units (index = FU_EXEC..FU_GR code).
REQ-003 SHALL have fu_req_i input NFU: unit n presents a result.
REQ-004 SHALL have fu_res_i input NFU x sFuncUnit: result per unit (cmt, rid, ele, res, cause, badAddr).
REQ-005 SHALL have fu_ack_o output NFU: unit n result accepted this cycle.
REQ-006 SHALL have flush_i input 1: discard all held and pending results.
REQ-007 SHALL have wb_v_o output 1: writeback record valid to ROB.
REQ-008 SHALL have wb_o output sFuncUnit: writeback record.
REQ-009 SHALL have wb_unit_o output 3: source unit code of wb_o.
REQ-010 SHALL have wb_rdy_i input 1: ROB update port accepts wb_o this cycle.
REQ-011 SHALL have stall_cnt_o output 16: saturating count of cycles with wb_v_o=1, wb_rdy_i=0.

Function
REQ-012 SHALL hold one result per unit in a hold buffer (hv[n], hb[n]).
REQ-013 SHALL drive fu_ack_o[n] = fu_req_i[n] & !flush_i & (!hv[n] | hold n granted this cycle).
REQ-014 SHALL capture fu_res_i[n] into hb[n] and set hv[n] on the edge where fu_req_i[n] & fu_ack_o[n].
REQ-015 SHALL treat the output register as free when !wb_v_o or wb_rdy_i.
REQ-016 SHALL, when output free and any hv set, grant exactly one unit and load its hold into wb_o/wb_unit_o, set wb_v_o, clear that hv (unless refilled same edge per REQ-013).
REQ-017 SHALL clear wb_v_o on an edge where wb_rdy_i=1 and no hold is valid.
REQ-018 SHALL hold wb_o, wb_unit_o, wb_v_o stable while wb_v_o=1 and wb_rdy_i=0.
REQ-019 SHALL give priority class 1 to holds with cause != FLT_NONE and class 0 otherwise; any class-1 hold beats all class-0 holds.
REQ-020 SHALL select within a class round-robin: search units rr, rr+1, ... modulo NFU; first valid wins.
REQ-021 SHALL update rr to (winner+1) mod NFU on each grant (5 -> 0 wrap), unchanged otherwise; one rr shared by both classes.
REQ-022 SHALL give minimum latency 2 cycles: req at edge N captured, wb_v_o=1 after edge N+1.
REQ-023 SHALL sustain one writeback per cycle when wb_rdy_i held 1 and holds available.
REQ-024 SHALL on flush_i=1 clear all hv and wb_v_o at the next edge; flush dominates capture and grant; rr and stall_cnt_o unchanged.
REQ-025 SHALL increment stall_cnt_o each edge with wb_v_o=1 & wb_rdy_i=0, saturating at 16'hFFFF.
REQ-026 SHALL ignore fu_req_i bits for unit codes >= NFU; wb_unit_o never takes values 6 or 7.

Reset
REQ-027 SHALL on rst_ni=0 asynchronously clear hv, wb_v_o, rr (=0), stall_cnt_o (=0), wb_o (=0), wb_unit_o (=0).
REQ-028 SHALL drive fu_ack_o=0 while rst_ni=0; a transfer in flight at reset assertion is dropped.
REQ-029 SHALL resume arbitration on the first rising edge after rst_ni deasserts.

Structure
REQ-030 SHALL add NFU_DEFAULT=6 and FLT_NONE-based class test helper to any1_pkg; reuse sFuncUnit and FU_* codes from any1_pkg.
REQ-031 SHALL place the modulo-NFU rotate-and-find-first in sub-module any1_rr_picker (req vector, rr in, grant one-hot + index out), instantiated once per class.
REQ-032 SHALL contain no other sub-modules; all state in the top module.

Verification
REQ-033 Single: fu_req_i[FU_MUL]=1 one cycle, rid=6'd3, wb_rdy_i=1 -> ack same cycle; wb_v_o=1, wb_o.rid=3, wb_unit_o=1 two edges later, one cycle only.
REQ-034 Round-robin: all 6 units req together, rids 0..5, cause=0, wb_rdy_i=1, rr=0 -> wb_unit_o sequence 0,1,2,3,4,5 on 6 consecutive cycles; rr returns 0.
REQ-035 Exception priority: units 0 and 4 held, unit 4 cause=8'h27, rr=0 -> unit 4 granted first, then unit 0; rr=1 after.
REQ-036 Backpressure: wb_rdy_i=0 for 10 cycles with unit 2 held and re-requesting -> wb_o stable, fu_ack_o[2]=0, stall_cnt_o=10; release -> stream resumes without loss.
REQ-037 Flush: 3 holds valid plus wb_v_o=1, flush_i=1 with new reqs -> no acks; next cycle hv all 0, wb_v_o=0; stall_cnt_o, rr unchanged.
REQ-038 Reset mid-stream: rst_ni=0 while wb_v_o=1 -> outputs 0 immediately (async); stall_cnt_o=0xFFFF pre-reset reads 0.
